// File: rtl/circle_buf_reader_pkg.sv
// circle_buf_reader_pkg
//   Shared definitions for the circular-buffer readout sequencer:
//   FSM state encoding and the layout of the optional 2-word bank header.
package circle_buf_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HDR0,
    S_HDR1,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Header words, in stream order, captured when a bank starts.
  localparam int HDR_STAT_IDX  = 0;
  localparam int HDR_COUNT_IDX = 1;
  localparam int HDR_WORDS     = 2;

endpackage

// File: rtl/cbr_skid.sv
// cbr_skid
//   Two-entry FIFO between the buffer read port and the output stream.
//   Two entries cover the word already in flight from the buffer plus the
//   one at the output, so the stream can run at one word per cycle.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_data/in_valid      write side; in_ready high while not full
//   out_data/out_valid    head of FIFO; popped when out_valid & out_ready
//   count                 current occupancy (0..2)
module cbr_skid #(
  parameter int w = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [w-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [w-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   count
);

  logic [w-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults or full if/else); a missing branch would infer a latch.
  always_comb begin
    in_ready  = (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    out_data  = mem_q[rd_ptr_q];
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
  end

  assign count = count_q;

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it has been
  // written, and the occupancy count that gates reads is reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/circle_buf_reader.sv
// circle_buf_reader
//   Readout sequencer for a double-buffered circular capture buffer. Waits
//   for a full bank, optionally emits a 2-word header (stat, count), then
//   reads every address in order into a ready/valid stream. The strobe on
//   the final address is the buffer's flip command.
// Ports
//   clk, rst             clock (buffer oclk), synchronous active-high reset
//   arm                  pulse: read the next available bank once
//   cont                 1: keep reading banks back to back
//   cb_enable            buffer has a full bank ready
//   cb_addr / cb_stb     buffer read address / flip strobe (last address)
//   cb_dout              buffer data, one cycle after cb_addr
//   cb_stat / cb_count   buffer status words, captured at bank start
//   m_data/m_valid/m_ready/m_last   output stream
//   busy                 sequencer not idle
//   banks_done           completed-bank counter (wraps)
module circle_buf_reader
  import circle_buf_reader_pkg::*;
#(
  parameter int dw  = 16,
  parameter int aw  = 13,
  parameter int hdr = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          cont,
  input  logic          cb_enable,
  output logic [aw-1:0] cb_addr,
  output logic          cb_stb,
  input  logic [dw-1:0] cb_dout,
  input  logic [15:0]   cb_stat,
  input  logic [15:0]   cb_count,
  output logic [dw-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic [15:0]   banks_done
);

  state_t        state_q, state_d;
  logic [aw-1:0] addr_q, addr_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          armed_q, armed_d;
  logic [15:0]   banks_done_q, banks_done_d;
  logic [15:0]   hdr_q [HDR_WORDS];
  logic [15:0]   hdr_d [HDR_WORDS];

  logic          skid_in_valid, skid_in_ready, skid_out_valid, skid_pop;
  logic [dw:0]   skid_in_data, skid_out_data;
  logic [1:0]    skid_count;
  logic [2:0]    occupancy;
  logic [dw-1:0] hdr_word;

  // Skid entries carry {last, data}.
  cbr_skid #(.w(dw + 1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (skid_in_data),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_data  (skid_out_data),
    .out_valid (skid_out_valid),
    .out_ready (m_ready),
    .count     (skid_count)
  );

  // Slots committed after this cycle: a word leaving the skid this cycle
  // frees its slot now, which keeps the stream at one word per cycle.
  assign skid_pop  = skid_out_valid & m_ready;
  assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, skid_pop};

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    armed_d         = armed_q | arm;
    banks_done_d    = banks_done_q;
    hdr_d           = hdr_q;
    hdr_word        = '0;
    cb_stb          = 1'b0;
    skid_in_valid   = 1'b0;
    skid_in_data    = '0;

    // A word requested last cycle is always captured; slot accounting
    // guarantees the skid has room for it.
    if (inflight_q) begin
      skid_in_valid = 1'b1;
      skid_in_data  = {inflight_last_q, cb_dout};
    end

    unique case (state_q)
      S_IDLE: begin
        if ((armed_q | cont) && cb_enable) state_d = S_START;
      end
      S_START: begin
        hdr_d[HDR_STAT_IDX]  = cb_stat;
        hdr_d[HDR_COUNT_IDX] = cb_count;
        addr_d               = '0;
        // The request that started this bank is consumed; an arm arriving
        // right now stays pending for the next bank.
        armed_d              = arm;
        state_d              = (hdr != 0) ? S_HDR0 : S_READ;
      end
      S_HDR0: begin
        hdr_word[15:0] = hdr_q[HDR_STAT_IDX];
        skid_in_valid  = 1'b1;
        skid_in_data   = {1'b0, hdr_word};
        if (skid_in_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        hdr_word[15:0] = hdr_q[HDR_COUNT_IDX];
        skid_in_valid  = 1'b1;
        skid_in_data   = {1'b0, hdr_word};
        if (skid_in_ready) state_d = S_READ;
      end
      S_READ: begin
        if (occupancy < 3'd2) begin
          addr_d          = addr_q + 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = &addr_q;
          if (&addr_q) begin
            cb_stb  = cb_enable;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((skid_count == 2'd0) && !inflight_q) state_d = S_DONE;
      end
      S_DONE: begin
        // One idle cycle lets the buffer's enable reflect the flip.
        banks_done_d = banks_done_q + 16'd1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      armed_q         <= 1'b0;
      banks_done_q    <= 16'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      armed_q         <= armed_d;
      banks_done_q    <= banks_done_d;
    end
  end

  // Header capture is always written before it is read.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
  end

  assign cb_addr    = addr_q;
  assign m_data     = skid_out_data[dw-1:0];
  assign m_valid    = skid_out_valid;
  assign m_last     = skid_out_valid & skid_out_data[dw];
  assign busy       = (state_q != S_IDLE);
  assign banks_done = banks_done_q;

endmodule

// File: tb/tb_circle_buf_reader.sv
// tb_circle_buf_reader
//   Drives two reader instances (with and without header) against a
//   behavioural double-bank buffer. Each bank fill pushes the expected
//   stream into a queue; a monitor pops and compares accepted words.
module tb_circle_buf_reader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          cont = 1'b0;
  logic          m_ready = 1'b1;
  logic          use_h0 = 1'b0;
  logic          rand_ready = 1'b0;

  logic          cb_enable;
  logic [DW-1:0] cb_dout;
  logic [15:0]   cb_stat, cb_count;

  logic [AW-1:0] addr_h1, addr_h0, cb_addr;
  logic          stb_h1, stb_h0, cb_stb;
  logic [DW-1:0] data_h1, data_h0, m_data;
  logic          valid_h1, valid_h0, m_valid;
  logic          last_h1, last_h0, m_last;
  logic          busy_h1, busy_h0, busy;
  logic [15:0]   done_h1, done_h0, banks_done;
  logic          arm_h1, arm_h0, cont_h1, cont_h0;

  assign arm_h1  = arm & ~use_h0;
  assign arm_h0  = arm & use_h0;
  assign cont_h1 = cont & ~use_h0;
  assign cont_h0 = cont & use_h0;

  circle_buf_reader #(.dw(DW), .aw(AW), .hdr(1)) u_dut (
    .clk(clk), .rst(rst), .arm(arm_h1), .cont(cont_h1), .cb_enable(cb_enable),
    .cb_addr(addr_h1), .cb_stb(stb_h1), .cb_dout(cb_dout), .cb_stat(cb_stat),
    .cb_count(cb_count), .m_data(data_h1), .m_valid(valid_h1), .m_ready(m_ready),
    .m_last(last_h1), .busy(busy_h1), .banks_done(done_h1)
  );

  circle_buf_reader #(.dw(DW), .aw(AW), .hdr(0)) u_dut_nohdr (
    .clk(clk), .rst(rst), .arm(arm_h0), .cont(cont_h0), .cb_enable(cb_enable),
    .cb_addr(addr_h0), .cb_stb(stb_h0), .cb_dout(cb_dout), .cb_stat(cb_stat),
    .cb_count(cb_count), .m_data(data_h0), .m_valid(valid_h0), .m_ready(m_ready),
    .m_last(last_h0), .busy(busy_h0), .banks_done(done_h0)
  );

  assign cb_addr    = use_h0 ? addr_h0  : addr_h1;
  assign cb_stb     = use_h0 ? stb_h0   : stb_h1;
  assign m_data     = use_h0 ? data_h0  : data_h1;
  assign m_valid    = use_h0 ? valid_h0 : valid_h1;
  assign m_last     = use_h0 ? last_h0  : last_h1;
  assign busy       = use_h0 ? busy_h0  : busy_h1;
  assign banks_done = use_h0 ? done_h0  : done_h1;

  // ---------------- behavioural double-bank buffer ----------------
  logic [15:0] mem [2][NW];
  logic [15:0] bstat [2];
  logic [15:0] bcnt [2];
  int          filled [2]  = '{0, 0};
  int          drained [2] = '{0, 0};
  logic        rd_bank = 1'b0;
  logic        wr_bank = 1'b0;
  int          flips = 0;

  assign cb_enable = (filled[rd_bank] != drained[rd_bank]);
  assign cb_stat   = bstat[rd_bank];
  assign cb_count  = bcnt[rd_bank];

  always @(posedge clk) begin
    cb_dout <= mem[rd_bank][cb_addr];
    if (cb_stb) begin
      drained[rd_bank] <= drained[rd_bank] + 1;
      rd_bank          <= ~rd_bank;
      flips            <= flips + 1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        is_hdr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_bank(input logic b);
    if (!use_h0) begin
      exp_q.push_back('{data: bstat[b], last: 1'b0, is_hdr: 1'b1});
      exp_q.push_back('{data: bcnt[b],  last: 1'b0, is_hdr: 1'b1});
    end
    for (int a = 0; a < NW; a++)
      exp_q.push_back('{data: mem[b][a], last: (a == NW - 1), is_hdr: 1'b0});
  endtask

  task automatic fill_bank();
    for (int a = 0; a < NW; a++) mem[wr_bank][a] = 16'($urandom);
    bstat[wr_bank] = 16'($urandom);
    bcnt[wr_bank]  = 16'($urandom);
    push_bank(wr_bank);
    filled[wr_bank] = filled[wr_bank] + 1;
    wr_bank = ~wr_bank;
  endtask

  // ---------------- sink ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  int            issued = 0, acc_data = 0, pend_acc = 0, max_out = 0;
  int            stb_seen = 0, words_seen = 0;
  logic [AW-1:0] prev_addr = '0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      issued = 0; acc_data = 0; pend_acc = 0;
      prev_addr = cb_addr;
    end else begin
      acc_data += pend_acc;
      pend_acc = 0;
      if (cb_addr != prev_addr) issued++;
      prev_addr = cb_addr;
      if (issued - acc_data > max_out) max_out = issued - acc_data;
      if (cb_stb) begin
        stb_seen++;
        check("stb_addr", 32'(cb_addr), NW - 1);
        check("stb_enable", 32'(cb_enable), 1);
      end
      if (m_valid && m_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(e.data));
          check("m_last", 32'(m_last), 32'(e.last));
          if (!e.is_hdr) pend_acc = 1;
          words_seen++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_arm();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic wait_banks(input int target, input int budget);
    int n = 0;
    while (int'(banks_done) != target && n < budget) begin
      @(negedge clk); n++;
    end
    check("banks_done", 32'(banks_done), 32'(target));
  endtask

  task automatic wait_addr(input int a, input int budget);
    int n = 0;
    while (int'(cb_addr) != a && n < budget) begin
      @(negedge clk); n++;
    end
    check("addr_reached", 32'(cb_addr), 32'(a));
  endtask

  task automatic bank_end_checks(input int exp_stb, input int exp_flips);
    check("queue_drained", 32'(exp_q.size()), 0);
    check("stb_count", 32'(stb_seen), 32'(exp_stb));
    check("flip_count", 32'(flips), 32'(exp_flips));
    check("outstanding_le_2", 32'(max_out <= 2), 1);
    check("busy_after_bank", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   n, fills, flips0, stb0;
    logic busy_seen;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cb_addr", 32'(cb_addr), 0);
    check("rst_cb_stb", 32'(cb_stb), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_banks_done", 32'(banks_done), 0);

    // Single bank, sink always ready.
    fill_bank();
    pulse_arm();
    wait_banks(1, 400);
    bank_end_checks(1, 1);
    check("words_bank1", 32'(words_seen), 18);

    // Single bank, random backpressure.
    rand_ready = 1'b1;
    fill_bank();
    pulse_arm();
    wait_banks(2, 800);
    bank_end_checks(2, 2);
    check("words_bank2", 32'(words_seen), 36);

    // Continuous mode with a writer refilling whichever bank is free.
    cont = 1'b1;
    fills = 0; n = 0;
    while (int'(banks_done) != 5 && n < 3000) begin
      @(negedge clk); n++;
      if (fills < 3 && filled[wr_bank] == drained[wr_bank]) begin
        fill_bank();
        fills++;
      end
    end
    cont = 1'b0;
    check("banks_done_cont", 32'(banks_done), 5);
    bank_end_checks(5, 5);

    // Arm with nothing to read: stays idle until a bank arrives.
    rand_ready = 1'b0;
    pulse_arm();
    busy_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      busy_seen |= busy;
    end
    check("idle_while_disabled", 32'(busy_seen), 0);
    fill_bank();
    @(negedge clk);
    check("start_after_enable", 32'(busy), 1);
    fill_bank();
    wait_addr(5, 200);
    pulse_arm();
    wait_banks(7, 1000);
    repeat (40) @(negedge clk);
    check("one_extra_bank", 32'(banks_done), 7);
    bank_end_checks(7, 7);

    // Reset in the middle of a bank.
    rand_ready = 1'b1;
    fill_bank();
    pulse_arm();
    wait_addr(7, 400);
    rst = 1'b1;
    flips0 = flips;
    stb0 = stb_seen;
    @(negedge clk);
    check("midrst_cb_addr", 32'(cb_addr), 0);
    check("midrst_cb_stb", 32'(cb_stb), 0);
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_m_last", 32'(m_last), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_banks_done", 32'(banks_done), 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_no_flip", 32'(flips), 32'(flips0));
    check("midrst_no_stb", 32'(stb_seen), 32'(stb0));
    check("midrst_bank_still_full", 32'(cb_enable), 1);
    exp_q.delete();
    push_bank(rd_bank);
    pulse_arm();
    wait_banks(1, 800);
    bank_end_checks(stb0 + 1, flips0 + 1);

    // Data-only reader.
    @(negedge clk);
    rand_ready = 1'b0;
    use_h0 = 1'b1;
    stb0 = stb_seen;
    flips0 = flips;
    n = words_seen;
    fill_bank();
    pulse_arm();
    wait_banks(1, 400);
    bank_end_checks(stb0 + 1, flips0 + 1);
    check("words_nohdr", 32'(words_seen - n), NW);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
